// File: rtl/id_inst_queue_pkg.sv
// Shared constants and entry layout for the IF->ID instruction queue.
// Entry packs {pc, inst}; IDQ_ENTRY_WD matches the IF-to-ID bus width.
package id_inst_queue_pkg;

  localparam int IDQ_DEPTH    = 4;
  localparam int IDQ_PC_W     = 32;
  localparam int IDQ_INST_W   = 32;
  localparam int IDQ_ENTRY_WD = IDQ_PC_W + IDQ_INST_W;

  typedef struct packed {
    logic [IDQ_PC_W-1:0]   pc;
    logic [IDQ_INST_W-1:0] inst;
  } idq_entry_t;

endpackage

// File: rtl/id_inst_queue_ram.sv
// Queue storage: DEPTH x W register array, one write port, async read port.
// Latency: write visible on read port the cycle after; no backpressure (control lives in the parent).
module idq_ram
  import id_inst_queue_pkg::*;
#(
  parameter  int DEPTH = IDQ_DEPTH,
  parameter  int W     = IDQ_ENTRY_WD,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  logic [W-1:0]     wdata_i,
  input  logic [PTR_W-1:0] raddr_i,
  output logic [W-1:0]     rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  // Contents need no reset: the parent masks the read port with its occupancy count.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/id_inst_queue.sv
// IF->ID instruction queue with branch flush that can keep the delay-slot instruction.
// Latency 1 cycle (0 with IDQ_BYPASS_EN on an empty queue); in_ready drops only when full and ID stalls.
module id_inst_queue
  import id_inst_queue_pkg::*;
#(
  parameter  int DEPTH  = IDQ_DEPTH,
  parameter  int PC_W   = IDQ_PC_W,
  parameter  int INST_W = IDQ_INST_W,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              in_ready,
  output logic              out_valid,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  input  logic              out_ready,
  input  logic              flush,
  input  logic              keep_slot,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int EW    = PC_W + INST_W;

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d, remain;
  logic [EW-1:0]    rd_ent;
  logic             full, empty, deq, enq, bypass, we;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

`ifdef IDQ_BYPASS_EN
  assign bypass = empty & in_valid & out_ready & ~flush;
`else
  assign bypass = 1'b0;
`endif

  assign in_ready  = ~full | out_ready;
  assign out_valid = ~empty | bypass;
  assign deq       = ~empty & out_ready;
  assign enq       = in_valid & in_ready;
  assign remain    = count_q - CNT_W'(deq);
  assign count     = count_q;
  assign {out_pc, out_inst} = bypass ? {in_pc, in_inst} : (empty ? '0 : rd_ent);

  // Flush is judged on what remains after this cycle's dequeue (the branch itself).
  always_comb begin
    head_d  = head_q + PTR_W'(deq);
    tail_d  = tail_q;
    count_d = count_q;
    we      = 1'b0;
    if (flush) begin
      if (!keep_slot) begin
        tail_d  = head_d;
        count_d = '0;
      end else if (remain != '0) begin
        tail_d  = head_d + PTR_W'(1);
        count_d = CNT_W'(1);
      end else if (enq) begin
        we      = 1'b1;
        tail_d  = tail_q + PTR_W'(1);
        count_d = CNT_W'(1);
      end else begin
        count_d = '0;
      end
    end else begin
      we      = enq & ~bypass;
      tail_d  = tail_q + PTR_W'(we);
      count_d = count_q + CNT_W'(we) - CNT_W'(deq);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  idq_ram #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (tail_q),
    .wdata_i ({in_pc, in_inst}),
    .raddr_i (head_q),
    .rdata_o (rd_ent)
  );

endmodule
